// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard/redirect controller.
// Holds the fixed stage indices, the multi-cycle unit tracker states and
// the default general exception vector.
package pipe_ctrl_pkg;

  // Fixed stage positions; WB is always the last stage (NSTAGE-1)
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;

  // Default general exception vector (uncached boot region)
  localparam logic [31:0] EXC_BASE_DEF = 32'hBFC0_0380;

  // Handshake state for one multi-cycle unit channel
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mc_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of all pipeline-facing signals of the hazard controller.
// The slave modport is the controller's view; the master modport is the
// pipeline (and multi-cycle units) driving requests and consuming controls.
interface pipe_hazard_ctrl_if #(
  parameter int NSTAGE = 5,
  parameter int NMC    = 2,
  parameter int REGW   = 5
);

  // ID source operands
  logic [REGW-1:0]   id_rs;
  logic [REGW-1:0]   id_rt;
  logic              id_rs_rd;
  logic              id_rt_rd;

  // EX load tracking
  logic              ex_load;
  logic [REGW-1:0]   ex_rt;

  // Other stall requests
  logic              id_jb_stall;
  logic              if_stallreq;
  logic              mem_stallreq;

  // Multi-cycle unit handshake
  logic [NMC-1:0]    mc_req;
  logic [NMC-1:0]    mc_ready;
  logic [NMC-1:0]    mc_start;
  logic [NMC-1:0]    mc_cancel;

  // Exception / ERET from MEM
  logic              mem_exc;
  logic              mem_eret;
  logic [31:0]       mem_epc;

  // Pipeline controls
  logic [NSTAGE-1:0] stall;
  logic [NSTAGE-1:0] flush;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;

  // Performance counters
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_flush_cnt;

  modport master (
    output id_rs, id_rt, id_rs_rd, id_rt_rd,
    output ex_load, ex_rt,
    output id_jb_stall, if_stallreq, mem_stallreq,
    output mc_req, mc_ready,
    input  mc_start, mc_cancel,
    output mem_exc, mem_eret, mem_epc,
    input  stall, flush, redirect_valid, redirect_pc,
    input  perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_rs_rd, id_rt_rd,
    input  ex_load, ex_rt,
    input  id_jb_stall, if_stallreq, mem_stallreq,
    input  mc_req, mc_ready,
    output mc_start, mc_cancel,
    input  mem_exc, mem_eret, mem_epc,
    output stall, flush, redirect_valid, redirect_pc,
    output perf_stall_cnt, perf_flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_mc_track.sv
// One multi-cycle unit channel tracker (module mc_track).
// Issues a single start pulse when an op first appears in EX, waits for the
// unit's result, then holds the result slot until EX is allowed to advance.
// An exception aborts a running or finished op with a one-cycle cancel.
module mc_track
  import pipe_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ready,
  input  logic advance,
  input  logic kill,
  output logic start,
  output logic cancel,
  output logic busy
);

  mc_state_e state_q;
  mc_state_e state_d;

  // State register; reset drops any in-flight op silently since the unit
  // itself is reset by the same signal
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake pulses; an exception outranks a result
  // arriving in the same cycle, and pulses are suppressed during reset
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    cancel  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !kill) begin
          start   = !rst;
          state_d = RUN;
        end
      end
      RUN: begin
        if (kill) begin
          cancel  = !rst;
          state_d = IDLE;
        end else if (ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (kill) begin
          cancel  = !rst;
          state_d = IDLE;
        end else if (advance) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Busy depends only on state and request so EX stall never loops back
  // through the advance input
  assign busy = ((state_q == IDLE) && req) || (state_q == RUN);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard and redirect controller for the in-order MIPS core.
// Produces per-stage stall/flush vectors from load-use, branch-operand,
// bus-wait and multi-cycle-unit conditions, tracks each multi-cycle unit
// with its own handshake FSM, and generates the exception/ERET redirect.
// Optional feature: define HAZ_PERF_CNT_EN to build the stall and flush
// performance counters; otherwise both counter outputs read 0.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          NSTAGE   = 5,
  parameter int          NMC      = 2,
  parameter int          REGW     = 5,
  parameter logic [31:0] EXC_BASE = EXC_BASE_DEF
) (
  input  logic clk,
  input  logic rst,
  pipe_hazard_ctrl_if.slave bus
);

  logic              load_use;
  logic              exc_take;
  logic [NSTAGE-1:0] origin;
  logic [NSTAGE-1:0] stall_v;
  logic [NSTAGE-1:0] flush_v;
  logic              stall_acc;
  logic [NMC-1:0]    mc_busy;
  logic [NMC-1:0]    mc_start_v;
  logic [NMC-1:0]    mc_cancel_v;

  // A load in EX whose non-zero destination feeds a source ID really reads
  assign load_use = bus.ex_load && (bus.ex_rt != '0) &&
                    ((bus.id_rs_rd && (bus.id_rs == bus.ex_rt)) ||
                     (bus.id_rt_rd && (bus.id_rt == bus.ex_rt)));

  // An exception is only taken once the data bus has stopped waiting
  assign exc_take = bus.mem_exc && !bus.mem_stallreq;

  // Collect stall origins at the stage that must hold
  always_comb begin
    origin              = '0;
    origin[STG_ID]      = load_use || bus.id_jb_stall || bus.if_stallreq;
    origin[STG_EX]      = |mc_busy;
    origin[NSTAGE-1]    = origin[NSTAGE-1] || bus.mem_stallreq;
  end

  // A stage holds whenever it or any later stage is the origin of a stall
  always_comb begin
    stall_acc = 1'b0;
    stall_v   = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      stall_acc  = stall_acc | origin[i];
      stall_v[i] = stall_acc;
    end
  end

  // Bubble into the first advancing stage behind a held one; kill all on exception
  always_comb begin
    flush_v    = '0;
    flush_v[0] = exc_take;
    for (int i = 1; i < NSTAGE; i++) begin
      flush_v[i] = exc_take | (stall_v[i-1] & ~stall_v[i]);
    end
  end

  // One tracker per multi-cycle unit; EX advances whenever it is not held
  for (genvar k = 0; k < NMC; k++) begin : g_mc
    mc_track u_mc (
      .clk     (clk),
      .rst     (rst),
      .req     (bus.mc_req[k]),
      .ready   (bus.mc_ready[k]),
      .advance (~stall_v[STG_EX]),
      .kill    (exc_take),
      .start   (mc_start_v[k]),
      .cancel  (mc_cancel_v[k]),
      .busy    (mc_busy[k])
    );
  end

  assign bus.mc_start       = mc_start_v;
  assign bus.mc_cancel      = mc_cancel_v;
  assign bus.stall          = stall_v;
  assign bus.flush          = flush_v;
  assign bus.redirect_valid = exc_take;
  assign bus.redirect_pc    = bus.mem_eret ? bus.mem_epc : EXC_BASE;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] flush_cnt_q;
  logic [31:0] flush_cnt_d;

  // Count frozen-fetch cycles and taken exceptions, wrapping naturally
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall_v[0]};
    flush_cnt_d = flush_cnt_q + {31'd0, exc_take};
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.perf_stall_cnt = stall_cnt_q;
  assign bus.perf_flush_cnt = flush_cnt_q;
`else
  assign bus.perf_stall_cnt = 32'd0;
  assign bus.perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl.
// Inputs change on the falling edge; combinational outputs are sampled 1
// time unit later, well away from the rising edge that updates state.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  pipe_hazard_ctrl_if #(.NSTAGE(5), .NMC(2), .REGW(5)) bus ();

  pipe_hazard_ctrl #(.NSTAGE(5), .NMC(2), .REGW(5), .EXC_BASE(32'hBFC0_0380)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.id_rs        = '0;
    bus.id_rt        = '0;
    bus.id_rs_rd     = 1'b0;
    bus.id_rt_rd     = 1'b0;
    bus.ex_load      = 1'b0;
    bus.ex_rt        = '0;
    bus.id_jb_stall  = 1'b0;
    bus.if_stallreq  = 1'b0;
    bus.mem_stallreq = 1'b0;
    bus.mc_req       = '0;
    bus.mc_ready     = '0;
    bus.mem_exc      = 1'b0;
    bus.mem_eret     = 1'b0;
    bus.mem_epc      = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    bus.mc_req = 2'b01;
    #1;
    n_checks++;
    if (bus.mc_start !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL rst_start: got %b expected 00", bus.mc_start);
    end
    @(negedge clk);
    bus.mc_req = 2'b00;
    #1;
    n_checks++;
    if (bus.stall !== 5'b00000 || bus.flush !== 5'b00000 || bus.redirect_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rst_ctrl: got stall=%b flush=%b rv=%b expected 0/0/0", bus.stall, bus.flush, bus.redirect_valid);
    end
    n_checks++;
    if (bus.mc_cancel !== 2'b00 || bus.perf_stall_cnt !== 32'd0 || bus.perf_flush_cnt !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL rst_cnt: got cancel=%b sc=%0d fc=%0d expected 0/0/0", bus.mc_cancel, bus.perf_stall_cnt, bus.perf_flush_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    idle_inputs();
    bus.ex_load = 1'b1; bus.ex_rt = 5'd5; bus.id_rs = 5'd5; bus.id_rs_rd = 1'b1;
    #1;
    n_checks++;
    if (bus.stall !== 5'b00011 || bus.flush !== 5'b00100) begin
      n_fail++;
      $display("[TB] FAIL lu_rs: got stall=%b flush=%b expected 00011/00100", bus.stall, bus.flush);
    end
    @(negedge clk);
    bus.id_rs = 5'd7; bus.id_rt = 5'd5; bus.id_rt_rd = 1'b1;
    #1;
    n_checks++;
    if (bus.stall !== 5'b00011 || bus.flush !== 5'b00100) begin
      n_fail++;
      $display("[TB] FAIL lu_rt: got stall=%b flush=%b expected 00011/00100", bus.stall, bus.flush);
    end
    @(negedge clk);
    bus.ex_rt = 5'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
    #1;
    n_checks++;
    if (bus.stall !== 5'b00000 || bus.flush !== 5'b00000) begin
      n_fail++;
      $display("[TB] FAIL lu_r0: got stall=%b flush=%b expected 0/0", bus.stall, bus.flush);
    end
    @(negedge clk);
    bus.ex_rt = 5'd5; bus.id_rs = 5'd5; bus.id_rt = 5'd5; bus.id_rs_rd = 1'b0; bus.id_rt_rd = 1'b0;
    #1;
    n_checks++;
    if (bus.stall !== 5'b00000) begin
      n_fail++;
      $display("[TB] FAIL lu_noread: got stall=%b expected 00000", bus.stall);
    end
    @(negedge clk);
    idle_inputs();
    bus.id_jb_stall = 1'b1;
    #1;
    n_checks++;
    if (bus.stall !== 5'b00011 || bus.flush !== 5'b00100) begin
      n_fail++;
      $display("[TB] FAIL jb_stall: got stall=%b flush=%b expected 00011/00100", bus.stall, bus.flush);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_divider();
    @(negedge clk);
    idle_inputs();
    bus.mc_req = 2'b01;
    #1;
    n_checks++;
    if (bus.mc_start !== 2'b01 || bus.stall !== 5'b00111 || bus.flush !== 5'b01000) begin
      n_fail++;
      $display("[TB] FAIL div_start: got start=%b stall=%b flush=%b expected 01/00111/01000", bus.mc_start, bus.stall, bus.flush);
    end
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.mc_start !== 2'b00 || bus.stall !== 5'b00111) begin
        n_fail++;
        $display("[TB] FAIL div_run%0d: got start=%b stall=%b expected 00/00111", c, bus.mc_start, bus.stall);
      end
    end
    @(negedge clk);
    bus.mc_ready = 2'b01;
    #1;
    n_checks++;
    if (bus.mc_start !== 2'b00 || bus.stall !== 5'b00111) begin
      n_fail++;
      $display("[TB] FAIL div_ready: got start=%b stall=%b expected 00/00111", bus.mc_start, bus.stall);
    end
    @(negedge clk);
    bus.mc_ready = 2'b00;
    #1;
    n_checks++;
    if (bus.mc_start !== 2'b00 || bus.stall !== 5'b00000) begin
      n_fail++;
      $display("[TB] FAIL div_done: got start=%b stall=%b expected 00/00000", bus.mc_start, bus.stall);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.mc_start !== 2'b01 || bus.stall !== 5'b00111) begin
      n_fail++;
      $display("[TB] FAIL div_idle: got start=%b stall=%b expected 01/00111", bus.mc_start, bus.stall);
    end
    @(negedge clk);
    bus.mc_ready = 2'b01;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_ready_mem_stall();
    @(negedge clk);
    idle_inputs();
    bus.mc_req = 2'b01;
    @(negedge clk);
    bus.mc_ready = 2'b01; bus.mem_stallreq = 1'b1;
    #1;
    n_checks++;
    if (bus.mc_start !== 2'b00 || bus.stall !== 5'b11111 || bus.flush !== 5'b00000) begin
      n_fail++;
      $display("[TB] FAIL rms_ready: got start=%b stall=%b flush=%b expected 00/11111/00000", bus.mc_start, bus.stall, bus.flush);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus.mc_ready = 2'b00;
      #1;
      n_checks++;
      if (bus.mc_start !== 2'b00 || bus.stall !== 5'b11111) begin
        n_fail++;
        $display("[TB] FAIL rms_hold%0d: got start=%b stall=%b expected 00/11111", c, bus.mc_start, bus.stall);
      end
    end
    @(negedge clk);
    bus.mem_stallreq = 1'b0;
    #1;
    n_checks++;
    if (bus.mc_start !== 2'b00 || bus.stall !== 5'b00000) begin
      n_fail++;
      $display("[TB] FAIL rms_release: got start=%b stall=%b expected 00/00000", bus.mc_start, bus.stall);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.mc_start !== 2'b01 || bus.stall !== 5'b00111) begin
      n_fail++;
      $display("[TB] FAIL rms_idle: got start=%b stall=%b expected 01/00111", bus.mc_start, bus.stall);
    end
    @(negedge clk);
    bus.mc_ready = 2'b01;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_eret();
    @(negedge clk);
    idle_inputs();
    bus.mem_exc = 1'b1; bus.mem_eret = 1'b1; bus.mem_epc = 32'h8000_1234;
    #1;
    n_checks++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h8000_1234 || bus.flush !== 5'b11111) begin
      n_fail++;
      $display("[TB] FAIL eret: got rv=%b pc=%h flush=%b expected 1/80001234/11111", bus.redirect_valid, bus.redirect_pc, bus.flush);
    end
    @(negedge clk);
    bus.mem_eret = 1'b0;
    #1;
    n_checks++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'hBFC0_0380 || bus.flush !== 5'b11111) begin
      n_fail++;
      $display("[TB] FAIL exc_vec: got rv=%b pc=%h flush=%b expected 1/bfc00380/11111", bus.redirect_valid, bus.redirect_pc, bus.flush);
    end
    @(negedge clk);
    bus.mem_exc = 1'b0; bus.mem_eret = 1'b1;
    #1;
    n_checks++;
    if (bus.redirect_valid !== 1'b0 || bus.flush !== 5'b00000) begin
      n_fail++;
      $display("[TB] FAIL no_exc: got rv=%b flush=%b expected 0/00000", bus.redirect_valid, bus.flush);
    end
    @(negedge clk);
    idle_inputs();
    bus.mem_exc = 1'b1; bus.mc_req = 2'b01;
    #1;
    n_checks++;
    if (bus.mc_start !== 2'b00 || bus.flush !== 5'b11111) begin
      n_fail++;
      $display("[TB] FAIL exc_nostart: got start=%b flush=%b expected 00/11111", bus.mc_start, bus.flush);
    end
    @(negedge clk);
    bus.mem_exc = 1'b0;
    #1;
    n_checks++;
    if (bus.mc_start !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL exc_then_start: got start=%b expected 01", bus.mc_start);
    end
    @(negedge clk);
    bus.mc_ready = 2'b01;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_exc_during_run();
    @(negedge clk);
    idle_inputs();
    bus.mc_req = 2'b01;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus.mem_exc = 1'b1; bus.mem_stallreq = 1'b1;
      #1;
      n_checks++;
      if (bus.flush !== 5'b00000 || bus.redirect_valid !== 1'b0 || bus.mc_cancel !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL exr_wait%0d: got flush=%b rv=%b cancel=%b expected 00000/0/00", c, bus.flush, bus.redirect_valid, bus.mc_cancel);
      end
    end
    @(negedge clk);
    bus.mem_stallreq = 1'b0; bus.mc_ready = 2'b01;
    #1;
    n_checks++;
    if (bus.mc_cancel !== 2'b01 || bus.flush !== 5'b11111 || bus.redirect_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL exr_take: got cancel=%b flush=%b rv=%b expected 01/11111/1", bus.mc_cancel, bus.flush, bus.redirect_valid);
    end
    @(negedge clk);
    bus.mem_exc = 1'b0; bus.mc_ready = 2'b00;
    #1;
    n_checks++;
    if (bus.mc_cancel !== 2'b00 || bus.mc_start !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL exr_idle: got cancel=%b start=%b expected 00/01", bus.mc_cancel, bus.mc_start);
    end
    @(negedge clk);
    bus.mc_ready = 2'b01;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    idle_inputs();
    bus.mc_req = 2'b10;
    #1;
    n_checks++;
    if (bus.mc_start !== 2'b10 || bus.stall !== 5'b00111) begin
      n_fail++;
      $display("[TB] FAIL mul_start: got start=%b stall=%b expected 10/00111", bus.mc_start, bus.stall);
    end
    @(negedge clk);
    bus.mc_ready = 2'b11;
    #1;
    n_checks++;
    if (bus.mc_start !== 2'b00 || bus.stall !== 5'b00111) begin
      n_fail++;
      $display("[TB] FAIL mul_ready: got start=%b stall=%b expected 00/00111", bus.mc_start, bus.stall);
    end
    @(negedge clk);
    bus.mc_ready = 2'b00; bus.mc_req = 2'b00;
    #1;
    n_checks++;
    if (bus.stall !== 5'b00000 || bus.mc_start !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL mul_done: got stall=%b start=%b expected 00000/00", bus.stall, bus.mc_start);
    end
    @(negedge clk);
    bus.mc_req = 2'b01;
    #1;
    n_checks++;
    if (bus.mc_start !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL b2b_div: got start=%b expected 01", bus.mc_start);
    end
    @(negedge clk);
    bus.mc_ready = 2'b01;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_counters();
    logic [31:0] exp_sc;
    logic [31:0] exp_fc;
`ifdef HAZ_PERF_CNT_EN
    exp_sc = 32'd10;
    exp_fc = 32'd2;
`else
    exp_sc = 32'd0;
    exp_fc = 32'd0;
`endif
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.if_stallreq = 1'b1;
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus.if_stallreq = 1'b0;
      bus.mem_exc = 1'b1;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (bus.perf_stall_cnt !== exp_sc || bus.perf_flush_cnt !== exp_fc) begin
      n_fail++;
      $display("[TB] FAIL perf_cnt: got sc=%0d fc=%0d expected %0d/%0d", bus.perf_stall_cnt, bus.perf_flush_cnt, exp_sc, exp_fc);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.perf_stall_cnt !== 32'd0 || bus.perf_flush_cnt !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL perf_rst: got sc=%0d fc=%0d expected 0/0", bus.perf_stall_cnt, bus.perf_flush_cnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle_inputs();
    $display("[TB] starting pipe_hazard_ctrl bench");
    test_reset();
    test_load_use();
    test_divider();
    test_ready_mem_stall();
    test_eret();
    test_exc_during_run();
    test_back_to_back();
    test_counters();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard and redirect controller for the in-order MIPS core; successor to the fixed five-stage hazard unit. Generates per-stage stall and flush vectors from load-use, branch-resolve, bus-wait and multi-cycle-unit conditions. Tracks each multi-cycle unit (divider, multiplier, …) with its own handshake state machine, so a unit is never restarted while the pipeline is frozen. Also produces the exception/ERET redirect PC.

## Interface
- NSTAGE, 5: pipeline stages, index 0 = IF … NSTAGE-1 = WB; ID = 1, EX = 2, MEM = 3 fixed
- NMC, 2: multi-cycle unit channels (0 = div, 1 = mult)
- REGW, 5: register index width
- EXC_BASE, 32'hBFC00380: general exception vector
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- id_rs, id_rt  in  REGW  ID source registers
- id_rs_rd, id_rt_rd  in  1  source actually read
- ex_load  in  1  EX holds a load
- ex_rt  in  REGW  load destination
- id_jb_stall  in  1  branch operands not ready in ID
- if_stallreq  in  1  instruction bus wait
- mem_stallreq  in  1  data bus wait
- mc_req  in  NMC  EX holds an op for channel k
- mc_ready  in  NMC  unit k result valid (level)
- mc_start  out  NMC  one-cycle start pulse to unit k
- mc_cancel  out  NMC  one-cycle abort pulse to unit k
- mem_exc  in  1  exception/ERET present in MEM
- mem_eret  in  1  the event is ERET
- mem_epc  in  32  CP0 EPC
- stall  out  NSTAGE  per-stage hold
- flush  out  NSTAGE  per-stage bubble/kill
- redirect_valid  out  1  PC redirect this cycle
- redirect_pc  out  32  redirect target
- perf_stall_cnt, perf_flush_cnt  out  32  performance counters

## Operation
- Stall origins: load-use (ex_load & rt ≠ 0 & matched read source) → ID; id_jb_stall → ID; if_stallreq → ID; mc busy → EX; mem_stallreq → NSTAGE-1.
- stall[i] = 1 iff any origin ≥ i.
- exc_take = mem_exc & ~mem_stallreq.
- flush[i] = exc_take | (stall[i-1] & ~stall[i]) for i ≥ 1.
- flush[0] = exc_take.
- redirect_valid = exc_take.
- redirect_pc = mem_epc if mem_eret, else EXC_BASE.
- Per-channel FSM:
  - IDLE: if mc_req & ~exc_take, pulse mc_start and go to RUN.
  - RUN: if mc_ready, go to DONE.
  - DONE: if ~stall[2] (EX advances), go to IDLE.
  - mc busy (EX stall origin) = (IDLE & mc_req) | RUN.
  - DONE does not raise stall; it holds the result slot while later stages freeze.
- exc_take in RUN or DONE: pulse mc_cancel and go to IDLE.
- An exception outranks mc_ready in the same cycle.

## Timing
- Stall, flush and redirect are combinational from inputs and FSM state; zero latency.
- mc_start is asserted in the cycle the op is first seen in EX, then never again for that op.
- Earliest EX release is the cycle after mc_ready.
- mem_stallreq held with mem_exc: no flush and no redirect until the first cycle mem_stallreq is low.
- mc_ready asserted in IDLE: ignored.
- Reset values:
  - all FSMs IDLE
  - mc_start, mc_cancel 0
  - counters 0
  - stall, flush and redirect follow inputs (all 0 with inputs idle)
- Reset mid-RUN: FSM goes to IDLE with no mc_cancel. The unit is reset by the same rst.
- Counters:
  - perf_stall_cnt increments each cycle stall[0] = 1.
  - perf_flush_cnt increments each cycle exc_take = 1.
  - Both wrap modulo 2^32.

## Configuration
- HAZ_PERF_CNT_EN defined: both counters are implemented.
- Undefined: perf_stall_cnt and perf_flush_cnt are tied to 0 and no counter flops exist. All other behaviour is identical.

## Structure
- Package pipe_ctrl_pkg holds:
  - stage index constants (STG_IF = 0, STG_ID = 1, STG_EX = 2, STG_MEM = 3)
  - the mc FSM state enum (IDLE, RUN, DONE)
  - the EXC_BASE default
- Sub-module mc_track: one FSM channel (req, ready, advance, kill → start, cancel, busy), instanced NMC times in a generate loop.

## Test plan
- Load-use: ex_load = 1, ex_rt = 5, id_rs = 5, id_rs_rd = 1 → stall = 5'b00011, flush = 5'b00100 for one cycle. With ex_rt = 0 → no stall.
- Divider, 8-cycle: mc_req[0] held → mc_start[0] high exactly one cycle; stall = 5'b00111 until mc_ready. Next cycle stall = 0; FSM goes DONE → IDLE.
- mc_ready while mem_stallreq = 1 for 3 cycles: FSM stays DONE, mc_start stays low throughout, stall = 5'b11111. Then IDLE once stall clears.
- ERET: mem_exc = mem_eret = 1, mem_epc = 32'h8000_1234 → redirect_pc = 32'h8000_1234, flush = 5'b11111. Non-ERET → 32'hBFC00380.
- Exception during RUN with mem_stallreq = 1 for 2 cycles: no flush or redirect for 2 cycles. Then mc_cancel pulses once, flush = 5'b11111, FSM goes IDLE.
- HAZ_PERF_CNT_EN: 10 stall cycles and 2 exceptions → counters read 10 and 2. rst → 0. Without the macro both read 0.
